// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle LEGv8 control sequencer:
// states, instruction classes, immediate/ALU select codes and opcode patterns.
package ctrl_pkg;

    localparam int unsigned OPC_W     = 11;
    localparam int unsigned IMM_SEL_W = 3;
    localparam int unsigned ALU_OP_W  = 2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LDUR, CLS_STUR, CLS_B, CLS_CBZ, CLS_CBNZ, CLS_IW
    } instr_class_t;

    localparam logic [IMM_SEL_W-1:0] IMM_I  = 3'b000;
    localparam logic [IMM_SEL_W-1:0] IMM_D  = 3'b001;
    localparam logic [IMM_SEL_W-1:0] IMM_B  = 3'b010;
    localparam logic [IMM_SEL_W-1:0] IMM_CB = 3'b011;
    localparam logic [IMM_SEL_W-1:0] IMM_IW = 3'b100;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_PASSB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_RFUNC = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MOVE  = 2'b11;

    // '?' positions are don't-care bits for casez matching
    localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OP_ADDI = 11'b1001000100?;
    localparam logic [OPC_W-1:0] OP_SUBI = 11'b1101000100?;
    localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
    localparam logic [OPC_W-1:0] OP_B    = 11'b000101?????;
    localparam logic [OPC_W-1:0] OP_CBZ  = 11'b10110100???;
    localparam logic [OPC_W-1:0] OP_CBNZ = 11'b10110101???;
    localparam logic [OPC_W-1:0] OP_MOVZ = 11'b110100101??;

endpackage

// File: rtl/multicycle_control_fsm_classifier.sv
// Combinational opcode decoder: maps IR[31:21] to instruction class,
// immediate-type select and a valid flag. The sequencer registers these.
module opcode_classifier
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]     opcode,
    output instr_class_t         cls_c,
    output logic [IMM_SEL_W-1:0] imm_sel_c,
    output logic                 valid_c
);

    always_comb begin
        cls_c     = CLS_R;
        imm_sel_c = IMM_I;
        valid_c   = 1'b1;
        casez (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: cls_c = CLS_R;
            OP_ADDI, OP_SUBI:               cls_c = CLS_I;
            OP_LDUR: begin cls_c = CLS_LDUR; imm_sel_c = IMM_D;  end
            OP_STUR: begin cls_c = CLS_STUR; imm_sel_c = IMM_D;  end
            OP_B:    begin cls_c = CLS_B;    imm_sel_c = IMM_B;  end
            OP_CBZ:  begin cls_c = CLS_CBZ;  imm_sel_c = IMM_CB; end
            OP_CBNZ: begin cls_c = CLS_CBNZ; imm_sel_c = IMM_CB; end
            OP_MOVZ: begin cls_c = CLS_IW;   imm_sel_c = IMM_IW; end
            default: valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// ready handshakes, stall watchdog, sticky error flags and a retire counter.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_W-1:0]     opcode,
    input  logic                 alu_zero,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic [2:0]           state,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic [IMM_SEL_W-1:0] imm_sel,
    output logic                 alu_src,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 reg2_loc,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 illegal,
    output logic                 timeout,
    output logic [CNT_W-1:0]     instret
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t                st, st_nxt;
    instr_class_t          cls_q, cls_c;
    logic [IMM_SEL_W-1:0]  imm_sel_c;
    logic                  valid_c;
    logic [WD_W-1:0]       wdog;
    logic                  waiting, retire, illegal_set, timeout_set, wdog_expired;

    opcode_classifier u_classifier (
        .opcode    (opcode),
        .cls_c     (cls_c),
        .imm_sel_c (imm_sel_c),
        .valid_c   (valid_c)
    );

    assign state        = st;
    assign wdog_expired = (wdog == WD_W'(TIMEOUT - 1));

    // State, decoded class, sticky flags, watchdog and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_FETCH;
            cls_q   <= CLS_R;
            imm_sel <= IMM_I;
            illegal <= 1'b0;
            timeout <= 1'b0;
            instret <= '0;
            wdog    <= '0;
        end else begin
            st <= st_nxt;
            if (st == ST_DECODE) begin
                cls_q   <= cls_c;
                imm_sel <= imm_sel_c;
            end
            if (illegal_set) illegal <= 1'b1;
            if (timeout_set) timeout <= 1'b1;
            if (retire)      instret <= instret + CNT_W'(1);
            if (st_nxt != st)  wdog <= '0;
            else if (waiting)  wdog <= wdog + WD_W'(1);
        end
    end

    // Next state and per-state strobes; everything is quiet while in reset
    always_comb begin
        st_nxt      = st;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_src     = 1'b0;
        alu_op      = ALU_OP_ADD;
        reg2_loc    = 1'b0;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        waiting     = 1'b0;
        retire      = 1'b0;
        illegal_set = 1'b0;
        timeout_set = 1'b0;
        if (!rst) begin
            case (st)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        st_nxt   = ST_DECODE;
                    end else begin
                        waiting = 1'b1;
                        if (wdog_expired) begin
                            timeout_set = 1'b1;
                            st_nxt      = ST_ERR;
                        end
                    end
                end
                ST_DECODE: begin
                    if (valid_c) begin
                        st_nxt = ST_EXEC;
                    end else begin
                        illegal_set = 1'b1;
                        st_nxt      = ST_ERR;
                    end
                end
                ST_EXEC: begin
                    case (cls_q)
                        CLS_R: begin
                            alu_op = ALU_OP_RFUNC;
                            st_nxt = ST_WB;
                        end
                        CLS_I: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_OP_RFUNC;
                            st_nxt  = ST_WB;
                        end
                        CLS_LDUR: begin
                            alu_src = 1'b1;
                            st_nxt  = ST_MEM;
                        end
                        CLS_STUR: begin
                            alu_src  = 1'b1;
                            reg2_loc = 1'b1;
                            st_nxt   = ST_MEM;
                        end
                        CLS_B: begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                            retire   = 1'b1;
                            st_nxt   = ST_FETCH;
                        end
                        CLS_CBZ, CLS_CBNZ: begin
                            reg2_loc = 1'b1;
                            alu_op   = ALU_OP_PASSB;
                            pc_write = (cls_q == CLS_CBZ) ? alu_zero : !alu_zero;
                            pc_src   = pc_write;
                            retire   = 1'b1;
                            st_nxt   = ST_FETCH;
                        end
                        CLS_IW: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_OP_MOVE;
                            st_nxt  = ST_WB;
                        end
                        default: st_nxt = ST_ERR;
                    endcase
                end
                ST_MEM: begin
                    dmem_read  = (cls_q == CLS_LDUR);
                    dmem_write = (cls_q == CLS_STUR);
                    if (dmem_ready) begin
                        retire = (cls_q == CLS_STUR);
                        st_nxt = (cls_q == CLS_LDUR) ? ST_WB : ST_FETCH;
                    end else begin
                        waiting = 1'b1;
                        if (wdog_expired) begin
                            timeout_set = 1'b1;
                            st_nxt      = ST_ERR;
                        end
                    end
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == CLS_LDUR);
                    retire     = 1'b1;
                    st_nxt     = ST_FETCH;
                end
                ST_ERR:  st_nxt = ST_ERR;
                default: st_nxt = ST_ERR;
            endcase
        end
    end

endmodule
